// File: rtl/code_lock_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : code_lock_pkg                                                   |
// | Purpose  : Shared state encoding and counter-width helpers for code_lock.  |
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package code_lock_pkg;

  // Encoding is visible on the state output, so values are fixed explicitly.
  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_UNLOCKED = 2'd1,
    ST_PROGRAM  = 2'd2,
    ST_LOCKOUT  = 2'd3
  } state_e;

  localparam int unsigned STATE_W = 2;

  // Width of a counter that must hold every value 0..max_val inclusive.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // Widths for the default parameter set (fail count, digit index, timer).
  localparam int unsigned DEF_FAIL_W = cnt_w(3);
  localparam int unsigned DEF_IDX_W  = cnt_w(8);
  localparam int unsigned DEF_TMR_W  = cnt_w(16);

endpackage
`default_nettype wire

// File: rtl/lock_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : lock_timer                                                      |
// | Purpose  : Loadable down-counter timing the lockout period.                |
// | Ports    : clk      - clock                                                |
// |            rst      - synchronous active-high reset (count cleared)        |
// |            load     - load load_val into the counter                       |
// |            load_val - value to load                                        |
// |            dec      - decrement by one (stops at zero)                     |
// |            done     - counter is on its last cycle (count == 1)            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module lock_timer #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Asserted on the final lockout cycle so the owner leaves LOCKOUT on the
  // same edge that takes the count to zero.
  assign done = (count_q == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/code_lock.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : code_lock                                                       |
// | Purpose  : Digit-entry combination lock with reprogrammable password and   |
// |            timed lockout after repeated failed attempts.                   |
// | Ports    : CLK, CLR     - clock, synchronous active-high reset             |
// |            key_valid    - strobe, key_val carries a digit                  |
// |            key_val      - digit value                                      |
// |            enter        - submit attempt / commit new password             |
// |            change_req   - enter password programming (from UNLOCKED)       |
// |            lock_req     - relock / abort programming                       |
// |            unlocked     - state is UNLOCKED or PROGRAM                     |
// |            lockout      - state is LOCKOUT                                 |
// |            err          - one-cycle error pulse                            |
// |            state        - current state encoding                           |
// |            fail_cnt     - consecutive failed attempts                      |
// |            pwd_len      - committed password length                        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module code_lock
  import code_lock_pkg::*;
#(
  parameter int unsigned KEY_W       = 2,
  parameter int unsigned MAX_LEN     = 8,
  parameter int unsigned DEFAULT_LEN = 4,
  parameter int unsigned MAX_FAIL    = 3,
  parameter int unsigned LOCKOUT_CYC = 16
) (
  input  logic                         CLK,
  input  logic                         CLR,
  input  logic                         key_valid,
  input  logic [KEY_W-1:0]             key_val,
  input  logic                         enter,
  input  logic                         change_req,
  input  logic                         lock_req,
  output logic                         unlocked,
  output logic                         lockout,
  output logic                         err,
  output logic [STATE_W-1:0]           state,
  output logic [cnt_w(MAX_FAIL)-1:0]   fail_cnt,
  output logic [cnt_w(MAX_LEN)-1:0]    pwd_len
);

  localparam int unsigned FAIL_W = cnt_w(MAX_FAIL);
  localparam int unsigned IDX_W  = cnt_w(MAX_LEN);
  localparam int unsigned TMR_W  = cnt_w(LOCKOUT_CYC);
  localparam int unsigned SEL_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  state_e                          state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic                            miss_q, miss_d;
  logic [FAIL_W-1:0]               fail_q, fail_d;
  logic [IDX_W-1:0]                len_q, len_d;
  logic [MAX_LEN-1:0][KEY_W-1:0]   digits_q, digits_d;
  logic [MAX_LEN-1:0][KEY_W-1:0]   shadow_q, shadow_d;
  logic                            err_q, err_d;
  logic                            unlocked_q, lockout_q;

  logic                            tmr_load;
  logic                            tmr_done;
  logic [SEL_W-1:0]                sel;
  logic [FAIL_W-1:0]               fail_inc;
  logic                            key_hit;
  logic [IDX_W-1:0]                idx_inc;

  // sel is only used while idx < MAX_LEN, so truncation never aliases.
  assign sel      = idx_q[SEL_W-1:0];
  assign fail_inc = fail_q + FAIL_W'(1);
  assign key_hit  = (idx_q < len_q) && (digits_q[sel] == key_val);
  assign idx_inc  = (idx_q == IDX_W'(MAX_LEN)) ? idx_q : idx_q + IDX_W'(1);

  lock_timer #(
    .CNT_W (TMR_W)
  ) u_lock_timer (
    .clk      (CLK),
    .rst      (CLR),
    .load     (tmr_load),
    .load_val (TMR_W'(LOCKOUT_CYC)),
    .dec      (state_q == ST_LOCKOUT),
    .done     (tmr_done)
  );

  // Strobes are evaluated strictly by priority: the highest one asserted
  // owns the cycle even when it has no effect in the current state.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    miss_d   = miss_q;
    fail_d   = fail_q;
    len_d    = len_q;
    digits_d = digits_q;
    shadow_d = shadow_q;
    err_d    = 1'b0;
    tmr_load = 1'b0;

    case (state_q)
      ST_LOCKED: begin
        if (lock_req) begin
          idx_d  = '0;
          miss_d = 1'b0;
        end else if (enter) begin
          idx_d  = '0;
          miss_d = 1'b0;
          if ((idx_q == len_q) && !miss_q) begin
            state_d = ST_UNLOCKED;
            fail_d  = '0;
          end else begin
            err_d  = 1'b1;
            fail_d = fail_inc;
            if (fail_inc == FAIL_W'(MAX_FAIL)) begin
              state_d  = ST_LOCKOUT;
              tmr_load = 1'b1;
            end
          end
        end else if (key_valid) begin
          miss_d = miss_q | ~key_hit;
          idx_d  = idx_inc;
        end
      end

      ST_UNLOCKED: begin
        if (lock_req) begin
          state_d = ST_LOCKED;
          idx_d   = '0;
          miss_d  = 1'b0;
        end else if (!enter && !key_valid && change_req) begin
          state_d = ST_PROGRAM;
          idx_d   = '0;
        end
      end

      ST_PROGRAM: begin
        if (lock_req) begin
          state_d = ST_LOCKED;
          idx_d   = '0;
          miss_d  = 1'b0;
        end else if (enter) begin
          state_d = ST_UNLOCKED;
          idx_d   = '0;
          if (idx_q != '0) begin
            digits_d = shadow_q;
            len_d    = idx_q;
          end else begin
            err_d = 1'b1;
          end
        end else if (key_valid) begin
          if (idx_q == IDX_W'(MAX_LEN)) begin
            err_d = 1'b1;
          end else begin
            shadow_d[sel] = key_val;
            idx_d         = idx_q + IDX_W'(1);
          end
        end
      end

      ST_LOCKOUT: begin
        if (tmr_done) begin
          state_d = ST_LOCKED;
          fail_d  = '0;
          idx_d   = '0;
          miss_d  = 1'b0;
        end
      end

      default: begin
        state_d = ST_LOCKED;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q    <= ST_LOCKED;
      idx_q      <= '0;
      miss_q     <= 1'b0;
      fail_q     <= '0;
      len_q      <= IDX_W'(DEFAULT_LEN);
      digits_q   <= '0;
      shadow_q   <= '0;
      err_q      <= 1'b0;
      unlocked_q <= 1'b0;
      lockout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      miss_q     <= miss_d;
      fail_q     <= fail_d;
      len_q      <= len_d;
      digits_q   <= digits_d;
      shadow_q   <= shadow_d;
      err_q      <= err_d;
      unlocked_q <= (state_d == ST_UNLOCKED) || (state_d == ST_PROGRAM);
      lockout_q  <= (state_d == ST_LOCKOUT);
    end
  end

  assign state    = state_q;
  assign unlocked = unlocked_q;
  assign lockout  = lockout_q;
  assign err      = err_q;
  assign fail_cnt = fail_q;
  assign pwd_len  = len_q;

endmodule
`default_nettype wire

// File: tb/tb_code_lock.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_code_lock                                                    |
// | Purpose  : Self-checking bench for code_lock: directed scenarios followed  |
// |            by random episodes, every cycle compared to a queue-based model.|
// | Ports    : none                                                            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_code_lock;

  localparam int KEY_W       = 2;
  localparam int MAX_LEN     = 8;
  localparam int DEFAULT_LEN = 4;
  localparam int MAX_FAIL    = 3;
  localparam int LOCKOUT_CYC = 16;

  localparam int M_LOCKED   = 0;
  localparam int M_UNLOCKED = 1;
  localparam int M_PROGRAM  = 2;
  localparam int M_LOCKOUT  = 3;

  logic                            CLK = 1'b0;
  logic                            CLR;
  logic                            key_valid;
  logic [KEY_W-1:0]                key_val;
  logic                            enter;
  logic                            change_req;
  logic                            lock_req;
  logic                            unlocked;
  logic                            lockout;
  logic                            err;
  logic [1:0]                      state;
  logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt;
  logic [$clog2(MAX_LEN+1)-1:0]    pwd_len;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the password and entries are plain digit queues.
  int m_st;
  int m_pwd[$];
  int m_att[$];
  int m_prog[$];
  int m_fail;
  int m_lock;
  int m_err;

  always #5 CLK = ~CLK;

  code_lock #(
    .KEY_W       (KEY_W),
    .MAX_LEN     (MAX_LEN),
    .DEFAULT_LEN (DEFAULT_LEN),
    .MAX_FAIL    (MAX_FAIL),
    .LOCKOUT_CYC (LOCKOUT_CYC)
  ) dut (
    .CLK        (CLK),
    .CLR        (CLR),
    .key_valid  (key_valid),
    .key_val    (key_val),
    .enter      (enter),
    .change_req (change_req),
    .lock_req   (lock_req),
    .unlocked   (unlocked),
    .lockout    (lockout),
    .err        (err),
    .state      (state),
    .fail_cnt   (fail_cnt),
    .pwd_len    (pwd_len)
  );

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit att_matches();
    if (m_att.size() != m_pwd.size()) return 1'b0;
    foreach (m_att[i]) if (m_att[i] != m_pwd[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step(input bit c, input bit kv, input int kval,
                            input bit en, input bit ch, input bit lk);
    m_err = 0;
    if (c) begin
      m_st = M_LOCKED;
      m_pwd.delete();
      for (int i = 0; i < DEFAULT_LEN; i++) m_pwd.push_back(0);
      m_att.delete();
      m_prog.delete();
      m_fail = 0;
      m_lock = 0;
    end else begin
      case (m_st)
        M_LOCKED: begin
          if (lk) begin
            m_att.delete();
          end else if (en) begin
            if (att_matches()) begin
              m_st   = M_UNLOCKED;
              m_fail = 0;
            end else begin
              m_err = 1;
              m_fail++;
              if (m_fail == MAX_FAIL) begin
                m_st   = M_LOCKOUT;
                m_lock = LOCKOUT_CYC;
              end
            end
            m_att.delete();
          end else if (kv) begin
            if (m_att.size() <= MAX_LEN) m_att.push_back(kval);
          end
        end
        M_UNLOCKED: begin
          if (lk) begin
            m_st = M_LOCKED;
            m_att.delete();
          end else if (!en && !kv && ch) begin
            m_st = M_PROGRAM;
            m_prog.delete();
          end
        end
        M_PROGRAM: begin
          if (lk) begin
            m_st = M_LOCKED;
            m_att.delete();
          end else if (en) begin
            if (m_prog.size() > 0) m_pwd = m_prog;
            else m_err = 1;
            m_st = M_UNLOCKED;
          end else if (kv) begin
            if (m_prog.size() == MAX_LEN) m_err = 1;
            else m_prog.push_back(kval);
          end
        end
        default: begin
          m_lock--;
          if (m_lock == 0) begin
            m_st   = M_LOCKED;
            m_fail = 0;
            m_att.delete();
          end
        end
      endcase
    end
  endtask

  // One clock: drive at the falling edge, model on the rising edge,
  // compare at the next falling edge.
  task automatic cyc(input bit c, input bit kv, input int kval,
                     input bit en, input bit ch, input bit lk);
    int kv_local;
    kv_local   = kval;
    CLR        = c;
    key_valid  = kv;
    key_val    = kv_local[KEY_W-1:0];
    enter      = en;
    change_req = ch;
    lock_req   = lk;
    @(posedge CLK);
    model_step(c, kv, kval, en, ch, lk);
    @(negedge CLK);
    chk("state",    state,    m_st);
    chk("unlocked", unlocked, (m_st == M_UNLOCKED || m_st == M_PROGRAM) ? 1 : 0);
    chk("lockout",  lockout,  (m_st == M_LOCKOUT) ? 1 : 0);
    chk("err",      err,      m_err);
    chk("fail_cnt", fail_cnt, m_fail);
    chk("pwd_len",  pwd_len,  m_pwd.size());
  endtask

  task automatic idle();       cyc(0, 0, 0, 0, 0, 0); endtask
  task automatic key(input int v); cyc(0, 1, v, 0, 0, 0); endtask
  task automatic ent();        cyc(0, 0, 0, 1, 0, 0); endtask
  task automatic chg();        cyc(0, 0, 0, 0, 1, 0); endtask
  task automatic lck();        cyc(0, 0, 0, 0, 0, 1); endtask
  task automatic rst_cyc();    cyc(1, 0, 0, 0, 0, 0); endtask

  task automatic keys4(input int a, input int b, input int c, input int d);
    key(a); key(b); key(c); key(d);
  endtask

  task automatic open_pwd();
    int p[$];
    p = m_pwd;
    foreach (p[i]) key(p[i]);
    ent();
  endtask

  initial begin
    int cnt;
    int r;
    int n;
    CLR = 1'b1; key_valid = 1'b0; key_val = '0;
    enter = 1'b0; change_req = 1'b0; lock_req = 1'b0;
    @(negedge CLK);

    // Reset state
    rst_cyc();
    rst_cyc();
    chk("rst_pwd_len", pwd_len, DEFAULT_LEN);

    // Default password opens the lock
    keys4(0, 0, 0, 0); ent();
    chk("open_default", unlocked, 1);
    lck();

    // Three wrong attempts then a timed lockout that ignores keys
    for (int k = 0; k < MAX_FAIL; k++) begin
      keys4(0, 0, 1, 0); ent();
    end
    cnt = 0;
    while (lockout && cnt < 40) begin
      cnt++;
      cyc(0, 1, $urandom_range(0, 3), $urandom_range(0, 1), 0, 0);
    end
    chk("lockout_len", cnt, LOCKOUT_CYC);
    chk("after_lockout_state", state, M_LOCKED);
    chk("after_lockout_fail", fail_cnt, 0);

    // Program 3,1,2 and use it
    keys4(0, 0, 0, 0); ent();
    chg(); key(3); key(1); key(2); ent();
    chk("prog3_len", pwd_len, 3);
    lck(); key(3); key(1); key(2); ent();
    chk("open_312", unlocked, 1);
    lck(); keys4(0, 0, 0, 0); ent();
    chk("old_pwd_rejected", err, 1);

    // Overflow key while programming, then empty commit
    key(3); key(1); key(2); ent();
    chg();
    for (int i = 0; i < MAX_LEN; i++) key(i % 4);
    key(1);
    chk("overflow_err", err, 1);
    ent();
    chk("prog8_len", pwd_len, MAX_LEN);
    chg(); ent();
    chk("empty_commit_err", err, 1);
    chk("empty_commit_len", pwd_len, MAX_LEN);

    // Abort programming keeps the old password; enter beats key_valid
    chg(); key(1); key(1); lck();
    open_pwd();
    chk("abort_keeps_pwd", unlocked, 1);
    lck();
    for (int i = 0; i < MAX_LEN - 1; i++) key(m_pwd[i]);
    cyc(0, 1, m_pwd[MAX_LEN-1], 1, 0, 0);
    chk("enter_drops_key", err, 1);

    // CLR mid-lockout and mid-program
    for (int k = 0; k < MAX_FAIL; k++) begin
      key(0); ent();
      if (lockout) break;
    end
    idle(); idle();
    rst_cyc();
    chk("clr_lockout_state", state, M_LOCKED);
    chk("clr_lockout_len", pwd_len, DEFAULT_LEN);
    keys4(0, 0, 0, 0); ent();
    chk("clr_open_default", unlocked, 1);
    chg(); key(3); key(3);
    rst_cyc();
    chk("clr_prog_len", pwd_len, DEFAULT_LEN);
    keys4(0, 0, 0, 0); ent();
    chk("clr_prog_open", unlocked, 1);

    // Random episodes
    for (int e = 0; e < 300; e++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: begin
          int p[$];
          p = m_pwd;
          if ($urandom_range(0, 3) == 0) p[$urandom_range(0, p.size() - 1)] = $urandom_range(0, 3);
          foreach (p[i]) key(p[i]);
          ent();
        end
        3: begin
          n = $urandom_range(0, 9);
          for (int i = 0; i < n; i++) key($urandom_range(0, 3));
          ent();
        end
        4: lck();
        5: begin
          chg();
          n = $urandom_range(0, 9);
          for (int i = 0; i < n; i++) key($urandom_range(0, 3));
          if ($urandom_range(0, 3) == 0) lck(); else ent();
        end
        6: cyc(0, $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
               $urandom_range(0, 1), $urandom_range(0, 1));
        7: begin
          n = $urandom_range(1, 20);
          for (int i = 0; i < n; i++) idle();
        end
        8: if ($urandom_range(0, 4) == 0) rst_cyc(); else idle();
        default: ent();
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
